// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: response-owner states
// and default geometry.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W   = 30;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 4;

  // state | meaning
  // IDLE  | no read response due next cycle
  // RD_A  | read granted to port A last cycle, response goes to A
  // RD_B  | read granted to port B last cycle, response goes to B
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles port B was denied.
module starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read data memory.
// Port A (CPU) has priority unless port B has been starved for MAX_WAIT
// cycles. Read data returns one cycle after the grant to the owning port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       b_at_max;
  logic       b_force;

  starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (b_req && !b_gnt),
    .clr   (b_gnt || !b_req),
    .at_max(b_at_max)
  );

  // Grant selection; the reset level gates grants so nothing reaches the
  // memory while reset is held, even between clock edges.
  always_comb begin
    b_force = b_req && b_at_max;
    a_gnt   = reset && a_req && !b_force;
    b_gnt   = reset && b_req && (b_force || !a_req);
  end

  // Memory command mux from the granted port.
  always_comb begin
    mem_en    = a_gnt || b_gnt;
    mem_we    = 1'b0;
    mem_addr  = a_addr;
    mem_wdata = a_wdata;
    if (a_gnt) begin
      mem_we = a_we;
    end else if (b_gnt) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // State register: owner of the response arriving next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state depends only on this cycle's grant, from any state.
  always_comb begin
    state_d = IDLE;
    if (a_gnt && !a_we) begin
      state_d = RD_A;
    end else if (b_gnt && !b_we) begin
      state_d = RD_B;
    end
  end

  // Response outputs; rdata is the memory output for both ports.
  always_comb begin
    a_rvalid = (state_q == RD_A);
    b_rvalid = (state_q == RD_B);
    a_rdata  = mem_rdata;
    b_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous-read memory model.
module tb_dmem_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [16];

  int checks;
  int failures;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write in the enable cycle, read data one cycle later.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h12345678;
    mem[2] = 32'h22222222;
    mem[3] = 32'h33333333;
    mem_rdata = '0;
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 30'h4000, '0);
    drive_b(1'b1, 1'b0, 30'h4002, '0);

    // Reset held: requests present but nothing granted.
    #12;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_wait", dut.u_starve.cnt_q, 0);
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    #1 reset = 1'b1;

    // A read 0x4000, granted in the first cycle after reset release.
    #1 drive_a(1'b1, 1'b0, 30'h4000, '0);
    #1;
    chk("rd_a_gnt", a_gnt, 1);
    chk("rd_b_gnt", b_gnt, 0);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 30'h4000);
    next_cycle();
    drive_a(1'b0, 1'b0, '0, '0);
    #1;
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 32'h12345678);
    chk("rd_b_rvalid", b_rvalid, 0);
    chk("rd_idle_mem_en", mem_en, 0);

    // Same-address collision: A write wins, B reads the new value next.
    next_cycle();
    drive_a(1'b1, 1'b1, 30'h4001, 32'hCAFEF00D);
    drive_b(1'b1, 1'b0, 30'h4001, '0);
    #1;
    chk("col_a_gnt", a_gnt, 1);
    chk("col_b_gnt", b_gnt, 0);
    chk("col_mem_we", mem_we, 1);
    chk("col_mem_wdata", mem_wdata, 32'hCAFEF00D);
    next_cycle();
    drive_a(1'b0, 1'b0, '0, '0);
    #1;
    chk("col_b_gnt2", b_gnt, 1);
    chk("col_wr_no_rvalid", a_rvalid, 0);
    chk("col_mem_addr", mem_addr, 30'h4001);
    next_cycle();
    drive_b(1'b0, 1'b0, '0, '0);
    #1;
    chk("col_b_rvalid", b_rvalid, 1);
    chk("col_b_rdata", b_rdata, 32'hCAFEF00D);
    chk("col_a_rvalid", a_rvalid, 0);

    // Alternating reads A, B, A back to back.
    next_cycle();
    drive_a(1'b1, 1'b0, 30'h4000, '0);
    #1 chk("alt1_a_gnt", a_gnt, 1);
    next_cycle();
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b1, 1'b0, 30'h4002, '0);
    #1;
    chk("alt2_b_gnt", b_gnt, 1);
    chk("alt2_a_rvalid", a_rvalid, 1);
    chk("alt2_a_rdata", a_rdata, 32'h12345678);
    next_cycle();
    drive_b(1'b0, 1'b0, '0, '0);
    drive_a(1'b1, 1'b0, 30'h4003, '0);
    #1;
    chk("alt3_a_gnt", a_gnt, 1);
    chk("alt3_b_rvalid", b_rvalid, 1);
    chk("alt3_a_rvalid", a_rvalid, 0);
    chk("alt3_b_rdata", b_rdata, 32'h22222222);
    next_cycle();
    drive_a(1'b0, 1'b0, '0, '0);
    #1;
    chk("alt4_a_rvalid", a_rvalid, 1);
    chk("alt4_a_rdata", a_rdata, 32'h33333333);
    chk("alt4_b_rvalid", b_rvalid, 0);

    // Starvation: A requests continuously, B forced ahead on the fifth cycle.
    next_cycle();
    drive_a(1'b1, 1'b0, 30'h4000, '0);
    drive_b(1'b1, 1'b0, 30'h4002, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stv_b_denied", b_gnt, 0);
      chk("stv_a_gnt", a_gnt, 1);
      chk("stv_wait_cnt", dut.u_starve.cnt_q, i);
      next_cycle();
    end
    #1;
    chk("stv_b_forced", b_gnt, 1);
    chk("stv_a_denied", a_gnt, 0);
    chk("stv_mem_addr", mem_addr, 30'h4002);
    chk("stv_wait_max", dut.u_starve.cnt_q, 4);
    next_cycle();
    drive_b(1'b0, 1'b0, '0, '0);
    #1;
    chk("stv_wait_clr", dut.u_starve.cnt_q, 0);
    chk("stv_b_rvalid", b_rvalid, 1);
    chk("stv_b_rdata", b_rdata, 32'h22222222);
    chk("stv_a_rvalid", a_rvalid, 0);
    chk("stv_a_regnt", a_gnt, 1);
    next_cycle();
    drive_a(1'b0, 1'b0, '0, '0);

    // Reset in the response cycle of a B read discards the response.
    next_cycle();
    drive_b(1'b1, 1'b0, 30'h4002, '0);
    #1 chk("rr_b_gnt", b_gnt, 1);
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rr_b_rvalid", b_rvalid, 0);
    chk("rr_state", dut.state_q, 0);
    chk("rr_mem_en", mem_en, 0);
    chk("rr_b_gnt_held", b_gnt, 0);
    drive_b(1'b0, 1'b0, '0, '0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    #1;
    chk("rr_after_b_rvalid", b_rvalid, 0);
    chk("rr_after_a_rvalid", a_rvalid, 0);

    // Idle for ten cycles.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      #1;
      chk("idle_mem_en", mem_en, 0);
      chk("idle_a_rvalid", a_rvalid, 0);
      chk("idle_b_rvalid", b_rvalid, 0);
      chk("idle_wait_cnt", dut.u_starve.cnt_q, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, cycles port B may be denied before it is forced ahead of port A.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports a_req/a_we  in  1 each  CPU port: access request and write select.
REQ-007 SHALL have ports a_addr  in  ADDR_W and a_wdata  in  DATA_W  CPU port address and write data.
REQ-008 SHALL have ports a_gnt  out  1, a_rvalid  out  1 and a_rdata  out  DATA_W  CPU port: accept, read-data valid, read data.
REQ-009 SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid and b_rdata, with identical widths and meanings for the debug/dump port.
REQ-010 SHALL have ports mem_en/mem_we  out  1 each, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W and mem_rdata  in  DATA_W  single-port data memory, synchronous read with 1-cycle latency.

Function
REQ-011 SHALL grant at most one port per cycle; a grant is combinational in the cycle the request is accepted.
REQ-012 SHALL choose B if b_req && wait_cnt==MAX_WAIT; else A if a_req; else B if b_req; else none.
REQ-013 SHALL drive mem_en=1 and mem_we/mem_addr/mem_wdata from the granted port in its grant cycle; with no grant: mem_en=0, mem_we=0, others don't-care.
REQ-014 SHALL complete a granted write in the grant cycle, with no rvalid pulse.
REQ-015 SHALL pulse x_rvalid exactly one cycle after a granted read by port x, with x_rdata=mem_rdata in that cycle.
REQ-016 SHALL hold the other port's rvalid at 0 in that cycle.
REQ-017 SHALL sustain back-to-back reads/writes (one per cycle, either port, including alternating ports) with no bubble.
REQ-018 SHALL track the response owner with FSM states IDLE, RD_A, RD_B: next = RD_A/RD_B on a granted read by A/B, else IDLE, from any state.
REQ-019 SHALL increment wait_cnt (width clog2(MAX_WAIT+1)) each cycle b_req=1 and b_gnt=0, saturating at MAX_WAIT.
REQ-020 SHALL clear wait_cnt when b_gnt=1 or b_req=0.
REQ-021 SHALL deny A on a forced B grant (REQ-012); A keeps requesting, and a_req/a_addr/a_we/a_wdata are held stable by the requester until granted.
REQ-022 SHALL serve A in the same cycle when both ports request the same address simultaneously and wait_cnt<MAX_WAIT; B is served next cycle and sees A's write.
REQ-023 SHALL leave x_rdata unconstrained when x_rvalid=0.

Reset
REQ-024 SHALL, while reset=0, force state=IDLE, wait_cnt=0, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, mem_en=0, mem_we=0, independent of clk.
REQ-025 SHALL discard an outstanding read response when reset asserts in a RD_A/RD_B cycle; no rvalid follows deassertion.
REQ-026 SHALL allow a grant in the first rising edge after reset deasserts.

Structure
REQ-027 SHALL place the state enum (IDLE, RD_A, RD_B) and the default ADDR_W/DATA_W/MAX_WAIT constants in shared package dmem_arb_pkg.
REQ-028 SHALL implement the saturating wait counter as sub-module starve_counter (inputs inc, clr; output at_max).

Verification
REQ-029 SHALL cover: A read 0x4000, memory holds 0x12345678 -> a_gnt same cycle, a_rvalid=1 with a_rdata=0x12345678 next cycle, b_rvalid=0.
REQ-030 SHALL cover: a_req held high continuously, b_req high from cycle 0, MAX_WAIT=4 -> b_gnt=0 for 4 cycles, b_gnt=1 in cycle 5, wait_cnt=0 after.
REQ-031 SHALL cover: same cycle A write 0x4001=0xCAFEF00D and B read 0x4001 -> A granted, B granted next cycle, b_rdata=0xCAFEF00D.
REQ-032 SHALL cover: alternating A read 0x4000, B read 0x4002, A read 0x4003 on consecutive cycles -> rvalid sequence A,B,A with no gap and correct data.
REQ-033 SHALL cover: reset low in the cycle after a B read grant -> b_rvalid stays 0, state=IDLE, mem_en=0 immediately, without a clock edge.
REQ-034 SHALL cover: no requests for 10 cycles -> mem_en=0, both rvalid=0, wait_cnt=0 throughout.
